// File: rtl/execute_muldiv.sv
// RV32M execute-stage companion: operand forwarding, load-use
// detection, iterative shift-add multiplier and restoring divider.
module execute_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            is_md,
  input  logic [2:0]      funct3,
  input  logic            flush,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] reg_A,
  input  logic [XLEN-1:0] reg_B,
  input  logic [XLEN-1:0] previous,
  input  logic [XLEN-1:0] writeback,
  input  logic [4:0]      prev_rd,
  input  logic [4:0]      wb_rd,
  input  logic            prev_reg_we,
  input  logic            wb_reg_we,
  input  logic            prev_mem_rr,
  input  logic            wb_mem_rr,
  output logic            bubble,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy
);

  localparam int NMUL = XLEN / MUL_STEP;
  localparam int CW   = $clog2(XLEN + 1);
  localparam int W2   = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W2-1:0]   acc;
  logic [W2-1:0]   mcand;
  logic [XLEN-1:0] mplier;
  logic            b_neg;
  logic            hi_sel;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic            neg_q;
  logic            neg_r;
  logic            sel_rem;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            hz_prev;
  logic            hz_wb;
  logic            go;
  logic            issue;

  // Operand forwarding: previous stage beats writeback stage
  always_comb begin
    op_a = reg_A;
    if (prev_reg_we && prev_rd != 5'd0 && rs1 == prev_rd)
      op_a = previous;
    else if (wb_reg_we && wb_rd != 5'd0 && rs1 == wb_rd)
      op_a = writeback;
    op_b = reg_B;
    if (prev_reg_we && prev_rd != 5'd0 && rs2 == prev_rd)
      op_b = previous;
    else if (wb_reg_we && wb_rd != 5'd0 && rs2 == wb_rd)
      op_b = writeback;
  end

  assign hz_prev = prev_mem_rr && prev_reg_we &&
                   ((rs1 != 5'd0 && rs1 == prev_rd) ||
                    (rs2 != 5'd0 && rs2 == prev_rd));
  assign hz_wb   = wb_mem_rr && wb_reg_we &&
                   ((rs1 != 5'd0 && rs1 == wb_rd) ||
                    (rs2 != 5'd0 && rs2 == wb_rd));
  assign bubble  = in_valid && is_md && (hz_prev || hz_wb);
  assign go      = in_valid && is_md && !bubble && !flush;
  assign issue   = go && state == IDLE;
  assign stall   = rst_n && go && state != DONE;
  assign busy    = state != IDLE;

  logic            sgn;
  logic            a_neg;
  logic            bd_neg;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] sp_res;
  logic            a_sx;
  logic            b_sx;

  // Issue-time decode of operand signs and special divides
  always_comb begin
    sgn      = !funct3[0];
    a_neg    = sgn && op_a[XLEN-1];
    bd_neg   = sgn && op_b[XLEN-1];
    div_zero = op_b == '0;
    div_ovf  = sgn && op_b == '1 &&
               op_a == {1'b1, {(XLEN-1){1'b0}}};
    if (funct3[1])
      sp_res = div_zero ? op_a : '0;
    else
      sp_res = div_zero ? '1 : op_a;
    a_sx = funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10;
    b_sx = funct3[1:0] == 2'b01;
  end

  logic [W2-1:0]   pp;
  logic [W2-1:0]   acc_nx;
  logic            mul_last;

  // One multiplier step: add MUL_STEP shifted partial products;
  // a negative multiplier gets its sign weight removed on the last step
  always_comb begin
    mul_last = cnt == CW'(NMUL - 1);
    pp = '0;
    for (int i = 0; i < MUL_STEP; i++)
      if (mplier[i]) pp = pp + (mcand << i);
    acc_nx = acc + pp;
    if (mul_last && b_neg)
      acc_nx = acc_nx - (mcand << MUL_STEP);
  end

  logic [XLEN:0]   dr;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] div_res;
  logic            div_last;

  // One restoring-division step on magnitudes plus sign fix-up
  always_comb begin
    div_last = cnt == CW'(XLEN - 1);
    dr       = {rem, quo[XLEN-1]};
    ge       = dr >= {1'b0, dvs};
    rem_nx   = ge ? dr[XLEN-1:0] - dvs : dr[XLEN-1:0];
    quo_nx   = {quo[XLEN-2:0], ge};
    if (sel_rem)
      div_res = neg_r ? -rem_nx : rem_nx;
    else
      div_res = neg_q ? -quo_nx : quo_nx;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      b_neg        <= 1'b0;
      hi_sel       <= 1'b0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      sel_rem      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      cnt          <= '0;
      result_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          result_valid <= 1'b0;
          if (issue) begin
            cnt <= '0;
            if (!funct3[2]) begin
              acc    <= '0;
              mcand  <= {{XLEN{a_sx & op_a[XLEN-1]}}, op_a};
              mplier <= op_b;
              b_neg  <= b_sx & op_b[XLEN-1];
              hi_sel <= funct3[1:0] != 2'b00;
              state  <= MUL;
            end else if (div_zero || div_ovf) begin
              result       <= sp_res;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              rem     <= '0;
              quo     <= a_neg ? -op_a : op_a;
              dvs     <= bd_neg ? -op_b : op_b;
              neg_q   <= a_neg ^ bd_neg;
              neg_r   <= a_neg;
              sel_rem <= funct3[1];
              state   <= DIV;
            end
          end
        end
        MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            result       <= hi_sel ? acc_nx[W2-1:XLEN]
                                   : acc_nx[XLEN-1:0];
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (div_last) begin
            result       <= div_res;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: vector table, forwarding, load-use,
// flush, reset abort and back-to-back sequences.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        is_md = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic        flush = 1'b0;
  logic [4:0]  rs1 = 5'd1;
  logic [4:0]  rs2 = 5'd2;
  logic [31:0] reg_A = 32'd0;
  logic [31:0] reg_B = 32'd0;
  logic [31:0] previous = 32'd0;
  logic [31:0] writeback = 32'd0;
  logic [4:0]  prev_rd = 5'd0;
  logic [4:0]  wb_rd = 5'd0;
  logic        prev_reg_we = 1'b0;
  logic        wb_reg_we = 1'b0;
  logic        prev_mem_rr = 1'b0;
  logic        wb_mem_rr = 1'b0;
  logic        bubble;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;

  execute_muldiv #(.XLEN(32), .MUL_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .is_md(is_md),
    .funct3(funct3), .flush(flush),
    .rs1(rs1), .rs2(rs2),
    .reg_A(reg_A), .reg_B(reg_B),
    .previous(previous), .writeback(writeback),
    .prev_rd(prev_rd), .wb_rd(wb_rd),
    .prev_reg_we(prev_reg_we), .wb_reg_we(wb_reg_we),
    .prev_mem_rr(prev_mem_rr), .wb_mem_rr(wb_mem_rr),
    .bubble(bubble), .stall(stall),
    .result(result), .result_valid(result_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          lat;
  } vec_t;

  vec_t        vecs [18];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_exp = 32'd0;
  logic [31:0] mon_e;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: result %h", result);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", result, mon_e);
      end
    end
  end

  task automatic run_op(input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] e,
                        input int lat);
    int n;
    bit got;
    bit drop;
    @(negedge clk);
    funct3 = f;
    reg_A = a;
    reg_B = b;
    is_md = 1'b1;
    in_valid = 1'b1;
    prev_mem_rr = 1'b0;
    exp_q.push_back(e);
    last_exp = e;
    #1 check("stall_issue", {31'd0, stall}, 32'd1);
    n = 0;
    got = 0;
    drop = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      #1;
      n++;
      if (result_valid) got = 1;
      else if (!stall) drop = 1;
    end
    check("latency", n, lat);
    check("stall_hold", {31'd0, drop}, 32'd0);
    check("stall_done", {31'd0, stall}, 32'd0);
  endtask

  task automatic drop_op();
    @(negedge clk);
    in_valid = 1'b0;
    is_md = 1'b0;
    #1;
    check("valid_clear", {31'd0, result_valid}, 32'd0);
    check("busy_clear", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 9};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000,
                 32'h40000000, 9};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 9};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 9};
    vecs[4]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd0, 9};
    vecs[5]  = '{3'd2, 32'd2, 32'hFFFFFFFF, 32'd1, 9};
    vecs[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, 33};
    vecs[7]  = '{3'd6, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33};
    vecs[8]  = '{3'd4, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33};
    vecs[9]  = '{3'd7, 32'd100, 32'd7, 32'd2, 33};
    vecs[10] = '{3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[11] = '{3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 33};
    vecs[12] = '{3'd4, 32'd1234, 32'd0, 32'hFFFFFFFF, 1};
    vecs[13] = '{3'd7, 32'd5, 32'd0, 32'd5, 1};
    vecs[14] = '{3'd4, 32'h80000000, 32'hFFFFFFFF,
                 32'h80000000, 1};
    vecs[15] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1};
    vecs[16] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33};
    vecs[17] = '{3'd5, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 33};

    in_valid = 1'b1;
    is_md = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_result", result, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    in_valid = 1'b0;
    is_md = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b,
             vecs[i].e, vecs[i].lat);
      drop_op();
    end

    run_op(3'd0, 32'd6, 32'd7, 32'd42, 9);
    run_op(3'd5, 32'd9, 32'd2, 32'd4, 33);
    drop_op();

    rs1 = 5'd5;
    prev_rd = 5'd5;
    prev_reg_we = 1'b1;
    previous = 32'd11;
    wb_rd = 5'd5;
    wb_reg_we = 1'b1;
    writeback = 32'd13;
    run_op(3'd0, 32'd3, 32'd4, 32'd44, 9);
    drop_op();
    rs1 = 5'd1;
    rs2 = 5'd6;
    wb_rd = 5'd6;
    writeback = 32'd10;
    run_op(3'd0, 32'd3, 32'd4, 32'd30, 9);
    drop_op();

    rs1 = 5'd5;
    rs2 = 5'd2;
    wb_rd = 5'd0;
    wb_reg_we = 1'b0;
    @(negedge clk);
    prev_mem_rr = 1'b1;
    funct3 = 3'd0;
    reg_A = 32'd3;
    reg_B = 32'd4;
    in_valid = 1'b1;
    is_md = 1'b1;
    #1;
    check("lu_bubble", {31'd0, bubble}, 32'd1);
    check("lu_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    check("lu_no_issue", {31'd0, busy}, 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 32'd44, 9);
    drop_op();

    rs1 = 5'd1;
    prev_rd = 5'd0;
    prev_reg_we = 1'b0;
    @(negedge clk);
    funct3 = 3'd5;
    reg_A = 32'd1000;
    reg_B = 32'd3;
    in_valid = 1'b1;
    is_md = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b0;
    #1 check("flush_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle", {31'd0, busy}, 32'd0);
    check("flush_valid", {31'd0, result_valid}, 32'd0);
    check("flush_result", result, last_exp);
    repeat (30) @(negedge clk);
    run_op(3'd0, 32'd12, 32'd12, 32'd144, 9);
    drop_op();

    @(negedge clk);
    funct3 = 3'd0;
    reg_A = 32'd3;
    reg_B = 32'd5;
    in_valid = 1'b1;
    is_md = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_mid_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_valid", {31'd0, result_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    is_md = 1'b0;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op(3'd3, 32'h10000, 32'h30000, 32'd3, 9);
    drop_op();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
